// File: rtl/elevator_request_queue_if.sv
// Car-panel / motion-controller bundle for the elevator request queue.
// master drives requests and car position; slave is the queue itself.
interface elevator_request_queue_if #(
  parameter int unsigned NUM_FLOORS = 7,
  parameter int unsigned FLOOR_W    = 3
);
  logic                  r_nwr;
  logic [FLOOR_W-1:0]    requested_floor;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] queue_status;
  logic                  target_valid;
  logic [FLOOR_W-1:0]    target_floor;
  logic [1:0]            direction;
  logic                  req_error;

  modport master (
    output r_nwr, requested_floor, current_floor, arrived,
    input  queue_status, target_valid, target_floor, direction, req_error
  );

  modport slave (
    input  r_nwr, requested_floor, current_floor, arrived,
    output queue_status, target_valid, target_floor, direction, req_error
  );
endinterface

// File: rtl/elevator_request_queue.sv
// Pending-floor bitmap plus collective (SCAN) destination scheduler for one car.
// Target and direction are computed from the registered bitmap, one edge behind it.
module elevator_request_queue #(
  parameter int unsigned NUM_FLOORS = 7,
  parameter int unsigned FLOOR_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  elevator_request_queue_if.slave  bus
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  r_req_error;
  logic                  w_wr_ok;
  logic                  w_wr_bad;
  logic                  w_cf_ok;

  dir_e                  r_dir;
  dir_e                  w_dir_nxt;
  logic [FLOOR_W-1:0]    r_target;
  logic [FLOOR_W-1:0]    w_target_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;

  logic                  w_has_at;
  logic                  w_has_above;
  logic                  w_has_below;
  logic [FLOOR_W-1:0]    w_lo_above;
  logic [FLOOR_W-1:0]    w_hi_below;
  logic [FLOOR_W-1:0]    w_dist_up;
  logic [FLOOR_W-1:0]    w_dist_dn;

  assign w_wr_ok  = !bus.r_nwr && (32'(bus.requested_floor) <  NUM_FLOORS);
  assign w_wr_bad = !bus.r_nwr && (32'(bus.requested_floor) >= NUM_FLOORS);
  assign w_cf_ok  = 32'(bus.current_floor) < NUM_FLOORS;

  // Set from the panel, clear from arrival; clear applied last so it wins on the same floor.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (w_wr_ok && (bus.requested_floor == FLOOR_W'(i))) w_set[i] = 1'b1;
      if (bus.arrived && (bus.current_floor == FLOOR_W'(i))) w_clr[i] = 1'b1;
    end
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  // Nearest pending floors strictly above / below the car, and the car's own floor.
  always_comb begin
    w_has_at    = 1'b0;
    w_has_above = 1'b0;
    w_has_below = 1'b0;
    w_lo_above  = '0;
    w_hi_below  = '0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (r_pending[i] && (FLOOR_W'(i) > bus.current_floor)) begin
        w_has_above = 1'b1;
        w_lo_above  = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (r_pending[i] && (FLOOR_W'(i) < bus.current_floor)) begin
        w_has_below = 1'b1;
        w_hi_below  = FLOOR_W'(i);
      end
      if (r_pending[i] && (FLOOR_W'(i) == bus.current_floor)) w_has_at = 1'b1;
    end
    w_dist_up = w_lo_above - bus.current_floor;
    w_dist_dn = bus.current_floor - w_hi_below;
  end

  // Direction FSM next-state and target selection.
  always_comb begin
    w_dir_nxt    = r_dir;
    w_target_nxt = r_target;
    w_valid_nxt  = |r_pending;
    if (w_cf_ok) begin
      case (r_dir)
        DIR_IDLE: begin
          if (w_has_at) begin
            w_target_nxt = bus.current_floor;
            w_dir_nxt    = DIR_IDLE;
          end else if (w_has_above && (!w_has_below || (w_dist_up <= w_dist_dn))) begin
            w_target_nxt = w_lo_above;
            w_dir_nxt    = DIR_UP;
          end else if (w_has_below) begin
            w_target_nxt = w_hi_below;
            w_dir_nxt    = DIR_DOWN;
          end else begin
            w_dir_nxt    = DIR_IDLE;
          end
        end
        DIR_UP: begin
          if (w_has_at) begin
            w_target_nxt = bus.current_floor;
          end else if (w_has_above) begin
            w_target_nxt = w_lo_above;
          end else if (w_has_below) begin
            w_target_nxt = w_hi_below;
            w_dir_nxt    = DIR_DOWN;
          end else begin
            w_dir_nxt    = DIR_IDLE;
          end
        end
        DIR_DOWN: begin
          if (w_has_at) begin
            w_target_nxt = bus.current_floor;
          end else if (w_has_below) begin
            w_target_nxt = w_hi_below;
          end else if (w_has_above) begin
            w_target_nxt = w_lo_above;
            w_dir_nxt    = DIR_UP;
          end else begin
            w_dir_nxt    = DIR_IDLE;
          end
        end
        default: w_dir_nxt = DIR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending   <= '0;
      r_req_error <= 1'b0;
      r_dir       <= DIR_IDLE;
      r_target    <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_req_error <= w_wr_bad;
      r_dir       <= w_dir_nxt;
      r_target    <= w_target_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign bus.queue_status = r_pending;
  assign bus.target_valid = r_valid;
  assign bus.target_floor = r_target;
  assign bus.direction    = r_dir;
  assign bus.req_error    = r_req_error;

endmodule
